e_mdu: RTL and testbench
========================

# e_mdu

Multi-cycle multiply/divide unit in the execute stage, one stage upstream of the data-memory stage. It is started by mult/multu/div/divu and mthi/mtlo, and owns the architectural HI/LO registers. It supplies mfhi/mflo read data into the E/M pipeline register. It raises `busy` so the hazard unit can stall any later HI/LO-using instruction in decode while an operation is in flight.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (must be ≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  valid MDU instruction in E this cycle.
- `mdu_op`  in  3  operation code:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 reserved, treated as none
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `rd_hi`  in  1  read select: 1 selects HI, 0 selects LO (for mfhi/mflo).
- `busy`  out  1  operation in flight.
- `stall_req`  out  1  equals `busy | (start & mdu_op ∈ {1..4})`; the hazard unit consumes this.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `mdu_out`  out  32  equals `rd_hi ? hi : lo`; combinational and always valid.

## Operation
- State: IDLE and RUN. An internal counter `cnt` of 4+ bits, wide enough for max(MULT_CYCLES, DIV_CYCLES). Pending result registers `p_hi` and `p_lo`.
- IDLE, `start=1`, op 1–4:
  - Compute the result into `p_hi`/`p_lo` at this edge.
  - Load `cnt` with the op's cycle count and go to RUN.
- IDLE, `start=1`, op 5: HI ← A at this edge. Op 6: LO ← A at this edge. No busy.
- IDLE, op 0/7 or `start=0`: no state change.
- RUN: `cnt` decrements each edge. On the edge where `cnt==1`: HI←`p_hi`, LO←`p_lo`, go to IDLE.
- `start` is ignored in RUN, including mthi/mtlo. The hazard unit guarantees it is never asserted then; the bench checks that it is ignored.
- mult: signed 32×32→64. HI = product[63:32], LO = product[31:0].
- multu: the same product, unsigned.
- div: signed, quotient truncated toward zero, LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- divu: unsigned quotient/remainder.
- Divide by zero (B==0, div or divu):
  - Runs the full DIV_CYCLES with `busy` asserted.
  - HI/LO keep their previous values; the pending write is suppressed.
- `hi`/`lo` change only at:
  - completion edges,
  - mthi/mtlo edges,
  - reset.

## Timing
- Reset (synchronous, at edge): HI=0, LO=0, `busy`=0, state IDLE, `cnt`=0, `p_hi`=`p_lo`=0. `stall_req` then follows `start`/`mdu_op` combinationally.
- Reset during RUN aborts the operation. No HI/LO update happens, and `busy`=0 the next cycle.
- `start` sampled at edge T (op 1–4):
  - `busy`=1 during cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - The new HI/LO are visible from cycle T+N+1, when `busy`=0.
- `stall_req` is high in cycle T (via `start`) and in T+1…T+N (via `busy`). It therefore covers back-to-back mfhi in decode with no gap.
- mthi/mtlo sampled at edge T: new value visible from cycle T+1. `busy` stays 0.
- A new op may start in the first IDLE cycle (T+N+1). There is no dead cycle.

## Test plan
- mult: reset, then `start` mult with A=0xFFFFFFFE (−2), B=3 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- Signed div: A=−7 (0xFFFFFFF9), B=2 → `busy` for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Overflow div: 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: mthi 0x1234, mtlo 0x5678 (each visible the next cycle, `busy` 0), then divu A=9, B=0 → `busy` 10 cycles; HI=0x1234, LO=0x5678 unchanged. Then:
  - Assert mthi 0xAAAA mid-RUN → ignored.
  - `mdu_out` with `rd_hi=1` returns 0x1234.
- Reset mid-RUN: start div 100/7, assert `reset` at the 4th busy cycle → next cycle `busy`=0, HI=LO=0. A following mult 6×7 started immediately yields LO=42, HI=0 after 5 cycles.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning HI/LO, with busy/stall signalling
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1) > 4 ? $clog2(MAXC + 1) : 4;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [31:0] p_hi, p_lo, dv, sq, sr, uq, ur, res_hi, res_lo;
  logic [63:0] sprod, uprod, prod;
  logic p_skip, long_op, is_div, dz, ovf;
  assign long_op = start && mdu_op >= 3'd1 && mdu_op <= 3'd4;
  assign is_div  = mdu_op == 3'd3 || mdu_op == 3'd4;
  assign dz      = B == 32'd0;
  assign ovf     = mdu_op == 3'd3 && A == 32'h8000_0000 && B == 32'hFFFF_FFFF;
  always_comb begin
    dv     = (dz || ovf) ? 32'd1 : B;
    sprod  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    uprod  = {32'd0, A} * {32'd0, B};
    prod   = mdu_op == 3'd1 ? sprod : uprod;
    sq     = $signed(A) / $signed(dv);
    sr     = $signed(A) % $signed(dv);
    uq     = A / dv;
    ur     = A % dv;
    res_hi = mdu_op == 3'd3 ? sr : mdu_op == 3'd4 ? ur : prod[63:32];
    res_lo = mdu_op == 3'd3 ? sq : mdu_op == 3'd4 ? uq : prod[31:0];
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb nxt = state == IDLE ? (long_op ? RUN : IDLE) : (cnt == CW'(1) ? IDLE : RUN);
  always_comb begin
    busy      = state == RUN;
    stall_req = busy | long_op;
    mdu_out   = rd_hi ? hi : lo;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      p_skip <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (long_op) begin
        p_hi   <= res_hi;
        p_lo   <= res_lo;
        p_skip <= is_div && dz;
        cnt    <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (start && mdu_op == 3'd5) begin
        hi <= A;
      end else if (start && mdu_op == 3'd6) begin
        lo <= A;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && !p_skip) begin
        hi <= p_hi;
        lo <= p_lo;
      end
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: table-driven and randomized self-checking bench for e_mdu
module tb_e_mdu;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, rd_hi = 1'b0;
  logic [2:0] mdu_op = 3'd0;
  logic [31:0] A = '0, B = '0;
  logic busy, stall_req;
  logic [31:0] hi, lo, mdu_out;
  int passed = 0, total = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .rd_hi(rd_hi), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] u;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (op)
      3'd1: begin q = x * y; exp_hi = q[63:32]; exp_lo = q[31:0]; end
      3'd2: begin u = {32'd0, a} * {32'd0, b}; exp_hi = u[63:32]; exp_lo = u[31:0]; end
      3'd3: if (b != 0) begin q = x / y; r = x % y; exp_hi = r[31:0]; exp_lo = q[31:0]; end
      3'd4: if (b != 0) begin exp_hi = a % b; exp_lo = a / b; end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inj);
    int n, want;
    logic [31:0] old_hi;
    want = (op == 1 || op == 2) ? 5 : (op == 3 || op == 4) ? 10 : 0;
    old_hi = exp_hi;
    @(negedge clk);
    start = 1'b1; mdu_op = op; A = a; B = b;
    #1 chk("stall_req_at_start", {31'd0, stall_req}, {31'd0, want > 0});
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      n++;
      if (n == 1) chk("hi_held_while_busy", hi, old_hi);
      if (inj && n == 3) begin start = 1'b1; mdu_op = 3'd5; A = 32'hAAAA; end
    end
    chk("busy_cycles", n, want);
    model(op, a, b);
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
    rd_hi = $urandom_range(0, 1);
    #1 chk("mdu_out", mdu_out, rd_hi ? exp_hi : exp_lo);
  endtask
  initial begin
    vec_t vecs[4];
    vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      chk("vec_hi", hi, vecs[i].hi);
      chk("vec_lo", lo, vecs[i].lo);
    end
    run_op(3'd5, 32'h1234, 32'd0, 1'b0);
    run_op(3'd6, 32'h5678, 32'd0, 1'b0);
    run_op(3'd4, 32'd9, 32'd0, 1'b1);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h5678);
    rd_hi = 1'b1;
    #1 chk("dz_mdu_out", mdu_out, 32'h1234);
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    start = 1'b1; mdu_op = 3'd1; A = 32'd6; B = 32'd7;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("post_abort_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("post_abort_done", {31'd0, busy}, 32'd0);
    chk("post_abort_lo", lo, 32'd42);
    chk("post_abort_hi", hi, 32'd0);
    exp_lo = 32'd42;
    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
      run_op(op, a, b, op >= 3'd3 && op <= 3'd4 && $urandom_range(0, 1) == 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
